dff_bank_rr_arbiter: RTL

- Round-robin arbiter that shares one WIDTH-bit D flip-flop register bank (the shared q register) between NREQ requesters.
- Grants write ownership one requester at a time, with bounded bursts so no requester can starve the others.
- The winning requester's data is clocked into the shared register every granted cycle.
- Sits between the producer blocks and the shared register consumers.

---
 rtl/dff_bank_rr_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register bank across NREQ requesters.
// Grants last at most MAX_BURST writes, then hand off directly with no idle bubble.
module dff_bank_rr_arbiter #(
  parameter  int NREQ      = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 4,
  localparam int OWNER_W   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [OWNER_W-1:0]    owner,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [NREQ-1:0]    gnt_nxt;
  logic [OWNER_W-1:0] owner_nxt;
  logic [CNT_W-1:0]   burst_cnt, cnt_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               q_valid_nxt;

  logic [OWNER_W-1:0] winner;
  logic [OWNER_W-1:0] cand;
  logic               found;
  logic [NREQ-1:0]    win_onehot;
  logic [WIDTH-1:0]   own_dat;
  logic               own_req;
  logic               any_req;
  logic               burst_last;

  assign any_req    = |req;
  assign own_req    = req[owner];
  assign burst_last = (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign win_onehot = NREQ'(1) << winner;
  assign busy       = (state == GRANT);

  // Search owner+1, owner+2, ... wrapping; the current owner is examined last.
  always_comb begin
    winner = owner;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = OWNER_W'((int'(owner) + k) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    own_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (OWNER_W'(i) == owner) own_dat = wr_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    owner_nxt   = owner;
    cnt_nxt     = burst_cnt;
    q_nxt       = q;
    q_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          gnt_nxt   = win_onehot;
          owner_nxt = winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (own_req) begin
          q_nxt       = own_dat;
          q_valid_nxt = 1'b1;
          cnt_nxt     = burst_cnt + CNT_W'(1);
        end
        // Grant ends on release or burst exhaustion; owner re-wins only if alone.
        if (!own_req || burst_last) begin
          cnt_nxt = '0;
          if (any_req) begin
            gnt_nxt   = win_onehot;
            owner_nxt = winner;
          end else begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= OWNER_W'(NREQ - 1);
      burst_cnt <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      owner     <= owner_nxt;
      burst_cnt <= cnt_nxt;
      q         <= q_nxt;
      q_valid   <= q_valid_nxt;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule
